// File: rtl/uart_pkg.sv
// Shared UART definitions: RX framer states and link-wide defaults used by both TX and RX paths.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS   = 8;
    localparam int unsigned UART_CLK_PER_BIT = 87;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to RST_VAL.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive deframer (8N1, LSB first): writes good bytes to the RX FIFO and pulses
// frame_err / overrun for the status logic.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = UART_CLK_PER_BIT,
    parameter int unsigned DATA_BITS   = UART_DATA_BITS
) (
    input  logic                 uart_clk,
    input  logic                 uart_rst_n,
    input  logic                 uart_rx_pin,
    input  logic                 fifo_full,
    output logic                 fifo_w_en,
    output logic [DATA_BITS-1:0] fifo_w_data,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int unsigned          CNT_W    = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0]     CNT_HALF = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [2:0]           BIT_LAST = 3'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 wen_q, wen_d;
    logic                 ovr_q, ovr_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_s;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk_i  (uart_clk),
        .rst_ni (uart_rst_n),
        .d_i    (uart_rx_pin),
        .q_o    (rx_s)
    );

    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            wen_q   <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            wen_q   <= wen_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        wen_d   = 1'b0;
        ovr_d   = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                // fifo_full only matters here; fullness earlier in the frame is ignored
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end else if (fifo_full) begin
                        ovr_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        wen_d   = 1'b1;
                        data_d  = shift_q;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign fifo_w_en   = wen_q;
    assign fifo_w_data = data_q;
    assign overrun     = ovr_q;
    assign frame_err   = ferr_q;
    assign rx_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer: one instance at 8 clocks/bit, one at 87 clocks/bit.
module tb_uart_rx_framer;

    typedef struct {
        int         kind;   // 0 write, 1 overrun, 2 frame error
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pin  [2];
    logic       full [2];
    logic       wen  [2];
    logic [7:0] wdata[2];
    logic       ferr [2];
    logic       ovr  [2];
    logic       busy [2];

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_framer #(.CLK_PER_BIT(8)) dut8 (
        .uart_clk    (clk),
        .uart_rst_n  (rst_n),
        .uart_rx_pin (pin[0]),
        .fifo_full   (full[0]),
        .fifo_w_en   (wen[0]),
        .fifo_w_data (wdata[0]),
        .frame_err   (ferr[0]),
        .overrun     (ovr[0]),
        .rx_busy     (busy[0])
    );

    uart_rx_framer #(.CLK_PER_BIT(87)) dut87 (
        .uart_clk    (clk),
        .uart_rst_n  (rst_n),
        .uart_rx_pin (pin[1]),
        .fifo_full   (full[1]),
        .fifo_w_en   (wen[1]),
        .fifo_w_data (wdata[1]),
        .frame_err   (ferr[1]),
        .overrun     (ovr[1]),
        .rx_busy     (busy[1])
    );

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a frame's outcome comes from its stop bit and the FIFO state at the stop
    // sample; the pulse lands 2 sync cycles + half a bit + 9 bits + 1 after the pin falls.
    task automatic send(input int g, input logic [7:0] b, input logic stop,
                        input logic fullv, input bit jitter, input int nbits);
        int   p;
        int   k0;
        logic v;
        exp_t e;
        p  = (g == 0) ? 8 : 87;
        k0 = cyc;
        if (nbits == 10) begin
            e.kind = !stop ? 2 : (fullv ? 1 : 0);
            e.data = b;
            e.cyc  = k0 + 3 + p / 2 + 9 * p;
            exp_q[g].push_back(e);
        end
        for (int i = 0; i < nbits; i++) begin
            v = (i == 0) ? 1'b0 : ((i == 9) ? stop : b[i-1]);
            for (int c = 0; c < p; c++) begin
                pin[g]  = v;
                full[g] = (jitter && i < 9) ? 1'($urandom_range(0, 1)) : fullv;
                @(negedge clk);
            end
        end
    endtask

    task automatic idle(input int g, input int n);
        pin[g] = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_mon
        logic prev = 1'b0;
        int   n;
        int   kind;
        exp_t e;
        always @(negedge clk) begin
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                n = int'(wen[g]) + int'(ovr[g]) + int'(ferr[g]);
                if (n != 0) begin
                    kind = wen[g] ? 0 : (ovr[g] ? 1 : 2);
                    chk(n == 1, $sformatf("dut%0d pulse_onehot", g), n, 1);
                    chk(!prev, $sformatf("dut%0d pulse_consecutive", g), int'(prev), 0);
                    if (exp_q[g].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL dut%0d unexpected_pulse actual_kind=%0d expected=none (cycle %0d)",
                                 g, kind, cyc);
                    end else begin
                        e = exp_q[g].pop_front();
                        chk(kind == e.kind, $sformatf("dut%0d pulse_kind", g), kind, e.kind);
                        chk(cyc == e.cyc, $sformatf("dut%0d pulse_cycle", g), cyc, e.cyc);
                        if (e.kind == 0)
                            chk(wdata[g] == e.data, $sformatf("dut%0d w_data", g),
                                int'(wdata[g]), int'(e.data));
                    end
                end
                prev = (n != 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k0;
        logic [7:0] b;
        logic       st;
        pin[0] = 1'b1; pin[1] = 1'b1;
        full[0] = 1'b0; full[1] = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++)
            chk({wen[g], ovr[g], ferr[g], busy[g], wdata[g]} == '0,
                $sformatf("dut%0d reset_outputs", g),
                int'({wen[g], ovr[g], ferr[g], busy[g], wdata[g]}), 0);
        rst_n = 1'b1;
        idle(0, 5);

        send(0, 8'hA5, 1'b1, 1'b0, 1'b0, 10);
        idle(0, 10);

        send(0, 8'h00, 1'b1, 1'b0, 1'b0, 10);
        send(0, 8'hFF, 1'b1, 1'b0, 1'b0, 10);
        send(0, 8'h3C, 1'b1, 1'b0, 1'b0, 10);
        idle(0, 10);

        pin[0] = 1'b0;
        k0 = cyc;
        repeat (3) @(negedge clk);
        pin[0] = 1'b1;
        while (cyc < k0 + 6) @(negedge clk);
        chk(busy[0] == 1'b1, "glitch_busy_in_start", int'(busy[0]), 1);
        @(negedge clk);
        chk(busy[0] == 1'b0, "glitch_busy_cleared", int'(busy[0]), 0);
        idle(0, 10);

        send(0, 8'h5A, 1'b0, 1'b0, 1'b0, 10);
        repeat (40) @(negedge clk);
        chk(busy[0] == 1'b1, "held_low_busy", int'(busy[0]), 1);
        idle(0, 5);
        send(0, 8'h11, 1'b1, 1'b0, 1'b0, 10);
        idle(0, 10);

        send(0, 8'h77, 1'b1, 1'b1, 1'b0, 10);
        full[0] = 1'b0;
        idle(0, 5);
        send(0, 8'h78, 1'b1, 1'b0, 1'b0, 10);
        idle(0, 10);

        send(0, 8'hC3, 1'b1, 1'b0, 1'b0, 5);
        pin[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk(busy[0] == 1'b1, "busy_mid_frame", int'(busy[0]), 1);
        rst_n = 1'b0;
        #1;
        chk({wen[0], ovr[0], ferr[0], busy[0], wdata[0]} == '0, "midframe_reset_outputs",
            int'({wen[0], ovr[0], ferr[0], busy[0], wdata[0]}), 0);
        pin[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(0, 5);
        send(0, 8'h81, 1'b1, 1'b0, 1'b0, 10);
        idle(0, 10);

        send(1, 8'hA5, 1'b1, 1'b0, 1'b0, 10);
        idle(1, 10);

        for (int i = 0; i < 30; i++) begin
            b  = 8'($urandom);
            st = ($urandom_range(0, 4) != 0);
            send(0, b, st, 1'($urandom_range(0, 3) == 0), 1'b1, 10);
            if (!st) idle(0, $urandom_range(2, 5));
            else if ($urandom_range(0, 1) == 1) idle(0, $urandom_range(1, 3));
        end
        full[0] = 1'b0;
        idle(0, 20);

        for (int g = 0; g < 2; g++)
            chk(exp_q[g].size() == 0, $sformatf("dut%0d missing_pulses", g), exp_q[g].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
